// File: rtl/nibbler_pkg.sv
// Shared types and widths for the Nibbler 4-bit CPU execute stage.
package nibbler_pkg;

    localparam int unsigned NIB_W  = 4;
    localparam int unsigned ADDR_W = 8;

    typedef enum logic [NIB_W-1:0] {
        OP_NOP   = 4'h0,
        OP_LIT   = 4'h1,
        OP_ADDI  = 4'h2,
        OP_NANDI = 4'h3,
        OP_CMPI  = 4'h4,
        OP_IN    = 4'h5,
        OP_OUT   = 4'h6,
        OP_PAGE  = 4'h7,
        OP_JMP   = 4'h8,
        OP_JC    = 4'h9,
        OP_JNC   = 4'hA,
        OP_JZ    = 4'hB,
        OP_JNZ   = 4'hC,
        OP_ADDC  = 4'hD,
        OP_SUBI  = 4'hE,
        OP_HALT  = 4'hF
    } opcode_t;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } exec_state_t;

endpackage

// File: rtl/nibbler_execute_if.sv
// Fetch-to-execute bus plus architectural-state outputs of the execute stage.
interface nibbler_execute_if;
    import nibbler_pkg::*;

    logic              phase;
    logic [NIB_W-1:0]  instruction;
    logic [NIB_W-1:0]  operand;
    logic [NIB_W-1:0]  data_in;
    logic [NIB_W-1:0]  acc;
    logic              carry;
    logic              zero;
    logic [NIB_W-1:0]  out_port;
    logic              out_strobe;
    logic              pc_load;
    logic [ADDR_W-1:0] pc_target;
    logic              halted;

    modport master (
        output phase, instruction, operand, data_in,
        input  acc, carry, zero, out_port, out_strobe, pc_load, pc_target, halted
    );

    modport slave (
        input  phase, instruction, operand, data_in,
        output acc, carry, zero, out_port, out_strobe, pc_load, pc_target, halted
    );

endinterface

// File: rtl/nibbler_alu.sv
// Combinational ALU: computes the result and which architectural fields it updates.
module nibbler_alu
    import nibbler_pkg::*;
(
    input  opcode_t          i_opcode,
    input  logic [NIB_W-1:0] i_a,
    input  logic [NIB_W-1:0] i_b,
    input  logic             i_cin,
    output logic [NIB_W-1:0] o_y_c,
    output logic             o_cout_c,
    output logic             o_z_c,
    output logic             o_writes_acc_c,
    output logic             o_writes_c_c,
    output logic             o_writes_z_c
);

    logic [NIB_W:0] w_sum;
    logic [NIB_W:0] w_diff;
    logic           w_add_cin;

    // Carry-in only participates for ADDC; diff MSB is the borrow out.
    assign w_add_cin = (i_opcode == OP_ADDC) & i_cin;
    assign w_sum     = (NIB_W+1)'(i_a) + (NIB_W+1)'(i_b) + (NIB_W+1)'(w_add_cin);
    assign w_diff    = (NIB_W+1)'(i_a) - (NIB_W+1)'(i_b);
    assign o_z_c     = (o_y_c == '0);

    always_comb begin
        o_y_c          = i_a;
        o_cout_c       = i_cin;
        o_writes_acc_c = 1'b0;
        o_writes_c_c   = 1'b0;
        o_writes_z_c   = 1'b0;
        case (i_opcode)
            OP_LIT, OP_IN: begin
                o_y_c          = i_b;
                o_writes_acc_c = 1'b1;
                o_writes_z_c   = 1'b1;
            end
            OP_NANDI: begin
                o_y_c          = ~(i_a & i_b);
                o_writes_acc_c = 1'b1;
                o_writes_z_c   = 1'b1;
            end
            OP_ADDI, OP_ADDC: begin
                o_y_c          = w_sum[NIB_W-1:0];
                o_cout_c       = w_sum[NIB_W];
                o_writes_acc_c = 1'b1;
                o_writes_c_c   = 1'b1;
                o_writes_z_c   = 1'b1;
            end
            OP_SUBI, OP_CMPI: begin
                o_y_c          = w_diff[NIB_W-1:0];
                o_cout_c       = ~w_diff[NIB_W];
                o_writes_acc_c = (i_opcode == OP_SUBI);
                o_writes_c_c   = 1'b1;
                o_writes_z_c   = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/nibbler_execute.sv
// Nibbler execute stage: phase edge detect, run/halt FSM, architectural registers,
// jump resolution and one-cycle pulse outputs.
module nibbler_execute
    import nibbler_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    nibbler_execute_if.slave   bus
);

    exec_state_t       r_state;
    exec_state_t       w_state_nxt;
    logic              r_phase_q;
    logic [NIB_W-1:0]  r_acc;
    logic              r_carry;
    logic              r_zero;
    logic [NIB_W-1:0]  r_page;
    logic [NIB_W-1:0]  r_out_port;
    logic              r_out_strobe;
    logic              r_pc_load;
    logic [ADDR_W-1:0] r_pc_target;
    logic              r_halted;

    opcode_t           w_opcode;
    logic              w_exec;
    logic              w_jump_take;
    logic [NIB_W-1:0]  w_alu_b;
    logic [NIB_W-1:0]  w_alu_y;
    logic              w_alu_cout;
    logic              w_alu_z;
    logic              w_wr_acc;
    logic              w_wr_c;
    logic              w_wr_z;

    // One execute event per rising phase, only while running.
    assign w_opcode = opcode_t'(bus.instruction);
    assign w_exec   = bus.phase & ~r_phase_q & (r_state == RUN);
    assign w_alu_b  = (w_opcode == OP_IN) ? bus.data_in : bus.operand;

    nibbler_alu u_alu (
        .i_opcode       (w_opcode),
        .i_a            (r_acc),
        .i_b            (w_alu_b),
        .i_cin          (r_carry),
        .o_y_c          (w_alu_y),
        .o_cout_c       (w_alu_cout),
        .o_z_c          (w_alu_z),
        .o_writes_acc_c (w_wr_acc),
        .o_writes_c_c   (w_wr_c),
        .o_writes_z_c   (w_wr_z)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= RUN;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RUN:     if (w_exec && (w_opcode == OP_HALT)) w_state_nxt = HALT;
            HALT:    w_state_nxt = HALT;
            default: w_state_nxt = RUN;
        endcase
    end

    // Jump conditions use the flags as they stood before this execute edge.
    always_comb begin
        w_jump_take = 1'b0;
        case (w_opcode)
            OP_JMP:  w_jump_take = 1'b1;
            OP_JC:   w_jump_take = r_carry;
            OP_JNC:  w_jump_take = ~r_carry;
            OP_JZ:   w_jump_take = r_zero;
            OP_JNZ:  w_jump_take = ~r_zero;
            default: w_jump_take = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_phase_q    <= 1'b0;
            r_acc        <= '0;
            r_carry      <= 1'b0;
            r_zero       <= 1'b0;
            r_page       <= '0;
            r_out_port   <= '0;
            r_out_strobe <= 1'b0;
            r_pc_load    <= 1'b0;
            r_pc_target  <= '0;
            r_halted     <= 1'b0;
        end else begin
            r_phase_q    <= bus.phase;
            r_out_strobe <= 1'b0;
            r_pc_load    <= 1'b0;
            r_halted     <= (w_state_nxt == HALT);
            if (w_exec) begin
                if (w_wr_acc) r_acc   <= w_alu_y;
                if (w_wr_c)   r_carry <= w_alu_cout;
                if (w_wr_z)   r_zero  <= w_alu_z;
                if (w_opcode == OP_PAGE) r_page <= bus.operand;
                if (w_opcode == OP_OUT) begin
                    r_out_port   <= r_acc;
                    r_out_strobe <= 1'b1;
                end
                if (w_jump_take) begin
                    r_pc_target <= {r_page, bus.operand};
                    r_pc_load   <= 1'b1;
                end
            end
        end
    end

    assign bus.acc        = r_acc;
    assign bus.carry      = r_carry;
    assign bus.zero       = r_zero;
    assign bus.out_port   = r_out_port;
    assign bus.out_strobe = r_out_strobe;
    assign bus.pc_load    = r_pc_load;
    assign bus.pc_target  = r_pc_target;
    assign bus.halted     = r_halted;

endmodule
